// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, frame length, FSM encoding and 3-bit index reversal for the FFT datapath
package fft_pkg;

  localparam int N   = 3;
  localparam int W   = 1 << N;
  localparam int PTS = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/bitrev_3.sv
// rtl/bitrev_3.sv - combinational 3-bit index reversal used for the write-slot address
module bitrev_3
  import fft_pkg::*;
(
  input  logic [2:0] idx,
  output logic [2:0] rev
);

  assign rev = bitrev3(idx);

endmodule

// File: rtl/fft_input_bitrev.sv
// rtl/fft_input_bitrev.sv - 8-point FFT input stage: collects a frame in bit-reversed slot order and holds it
// Build option FFT_INPUT_PINGPONG_EN: two frame banks for bubble-free streaming.
module fft_input_bitrev
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [W-1:0]         in_r,
  input  logic [W-1:0]         in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PTS*W-1:0]     out_r,
  output logic [PTS*W-1:0]     out_i,
  output logic                 frame_err
);

  logic [2:0] cnt;
  logic [2:0] slot;
  logic       in_xfer;
  logic       out_xfer;

  bitrev_3 u_bitrev (
    .idx (cnt),
    .rev (slot)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef FFT_INPUT_PINGPONG_EN
  logic [W-1:0] mem_r [2][PTS];
  logic [W-1:0] mem_i [2][PTS];
  logic         wr_bank;
  logic         rd_bank;
  logic [1:0]   full;

  // The write bank is only ever full when both banks are full.
  assign in_ready  = !rst && !full[wr_bank];
  assign out_valid = full[rd_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < PTS; s++) begin
          mem_r[b][s] <= '0;
          mem_i[b][s] <= '0;
        end
      end
    end else begin
      frame_err <= 1'b0;
      if (in_xfer) begin
        mem_r[wr_bank][slot] <= in_r;
        mem_i[wr_bank][slot] <= in_i;
        if (cnt == 3'(PTS - 1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          cnt           <= '0;
          frame_err     <= !in_last;
        end else if (in_last) begin
          cnt       <= '0;
          frame_err <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
      if (out_xfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_comb begin
    out_r = '0;
    out_i = '0;
    for (int s = 0; s < PTS; s++) begin
      out_r[s*W +: W] = mem_r[rd_bank][s];
      out_i[s*W +: W] = mem_i[rd_bank][s];
    end
  end
`else
  logic [W-1:0] mem_r [PTS];
  logic [W-1:0] mem_i [PTS];
  state_t       state;

  assign in_ready  = !rst && (state == FILL);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      frame_err <= 1'b0;
      for (int s = 0; s < PTS; s++) begin
        mem_r[s] <= '0;
        mem_i[s] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (in_xfer) begin
            mem_r[slot] <= in_r;
            mem_i[slot] <= in_i;
            if (cnt == 3'(PTS - 1)) begin
              state     <= HOLD;
              cnt       <= '0;
              frame_err <= !in_last;
            end else if (in_last) begin
              // Short frame: slots already written are simply overwritten by the next frame.
              cnt       <= '0;
              frame_err <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    out_r = '0;
    out_i = '0;
    for (int s = 0; s < PTS; s++) begin
      out_r[s*W +: W] = mem_r[s];
      out_i[s*W +: W] = mem_i[s];
    end
  end
`endif

endmodule

// File: tb/tb_fft_input_bitrev.sv
// tb/tb_fft_input_bitrev.sv - directed self-checking bench for fft_input_bitrev
module tb_fft_input_bitrev;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [7:0]  in_r;
  logic [7:0]  in_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_r;
  logic [63:0] out_i;
  logic        frame_err;

  int n_pass  = 0;
  int n_total = 0;
  int rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_input_bitrev dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .frame_err (frame_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_frame(input string tag, input int base);
    logic [63:0] er;
    logic [63:0] ei;
    er = '0;
    ei = '0;
    for (int s = 0; s < 8; s++) begin
      er[s*8 +: 8] = 8'(base + rev_tab[s]);
      ei[s*8 +: 8] = 8'(0 - (base + rev_tab[s]));
    end
    chk({tag, "_out_r"}, out_r, er);
    chk({tag, "_out_i"}, out_i, ei);
  endtask

  // Sends nsamp consecutive samples r=base+k, i=-(base+k); in_last on sample last_at.
  task automatic send(input string tag, input int base, input int nsamp, input int last_at);
    for (int k = 0; k < nsamp; k++) begin
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_r     = 8'(base + k);
      in_i     = 8'(0 - (base + k));
      in_last  = (k == last_at);
      step();
      if (k < nsamp - 1) begin
        chk({tag, "_err_mid"}, 64'(frame_err), 64'd0);
        chk({tag, "_valid_mid"}, 64'(out_valid), 64'd0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [63:0] held_r;
    logic [63:0] held_i;
    int          accepted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_r      = '0;
    in_i      = '0;
    out_ready = 1'b0;
    step();
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_out_r", out_r, 64'd0);
    chk("rst_out_i", out_i, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

`ifdef FFT_INPUT_PINGPONG_EN
    out_ready = 1'b1;
    accepted  = 0;
    for (int k = 0; k < 32; k++) begin
      chk("pp_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_r     = 8'(k);
      in_i     = 8'(0 - k);
      in_last  = ((k % 8) == 7);
      if (in_ready) accepted++;
      step();
      if ((k % 8) == 7) begin
        chk("pp_out_valid", 64'(out_valid), 64'd1);
        check_frame("pp_frame", k - 7);
      end
      chk("pp_frame_err", 64'(frame_err), 64'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("pp_accepted", 64'(accepted), 64'd32);
    step();
    chk("pp_drained", 64'(out_valid), 64'd0);
`else
    // Basic frame with consumer ready.
    out_ready = 1'b1;
    send("f0", 0, 8, 7);
    chk("f0_out_valid", 64'(out_valid), 64'd1);
    chk("f0_in_ready", 64'(in_ready), 64'd0);
    chk("f0_frame_err", 64'(frame_err), 64'd0);
    check_frame("f0", 0);
    step();
    chk("f0_consumed", 64'(out_valid), 64'd0);
    chk("f0_refill_ready", 64'(in_ready), 64'd1);
    chk("f0_err_after", 64'(frame_err), 64'd0);

    // Backpressure: frame held for 10 cycles, stray in_valid pulses ignored.
    out_ready = 1'b0;
    send("f1", 16, 8, 7);
    held_r = out_r;
    held_i = out_i;
    check_frame("f1", 16);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 2) || (c == 4) || (c == 6);
      in_r     = 8'h55;
      in_i     = 8'hAA;
      in_last  = in_valid;
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_r", out_r, held_r);
      chk("bp_out_i", out_i, held_i);
      chk("bp_frame_err", 64'(frame_err), 64'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_released", 64'(out_valid), 64'd0);
    send("f2", 32, 8, 7);
    chk("f2_out_valid", 64'(out_valid), 64'd1);
    check_frame("f2", 32);
    step();

    // Early in_last on 4th sample discards the partial frame.
    send("short", 100, 4, 3);
    chk("short_err_pulse", 64'(frame_err), 64'd1);
    chk("short_no_valid", 64'(out_valid), 64'd0);
    step();
    chk("short_err_clear", 64'(frame_err), 64'd0);
    chk("short_no_valid2", 64'(out_valid), 64'd0);
    send("f3", 48, 8, 7);
    chk("f3_out_valid", 64'(out_valid), 64'd1);
    chk("f3_frame_err", 64'(frame_err), 64'd0);
    check_frame("f3", 48);
    step();

    // Eight samples without in_last: frame presented with an error pulse.
    send("nolast", 64, 8, -1);
    chk("nolast_out_valid", 64'(out_valid), 64'd1);
    chk("nolast_err_pulse", 64'(frame_err), 64'd1);
    check_frame("nolast", 64);
    step();
    chk("nolast_err_clear", 64'(frame_err), 64'd0);
    chk("nolast_consumed", 64'(out_valid), 64'd0);

    // Reset mid-frame at cnt=5.
    send("prerst", 90, 5, -1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_r", out_r, 64'd0);
    chk("midrst_out_i", out_i, 64'd0);
    chk("midrst_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    #1;
    send("f4", 80, 8, 7);
    chk("f4_out_valid", 64'(out_valid), 64'd1);
    chk("f4_frame_err", 64'(frame_err), 64'd0);
    check_frame("f4", 80);
    step();
    chk("f4_consumed", 64'(out_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_input_bitrev.md
Name: fft_input_bitrev

Overview:
Input stage of the 8-point FFT datapath.
- Accepts one complex sample per cycle on a valid/ready stream.
- Collects a frame of 8 samples and presents them to the first radix-2 butterfly stage as a parallel 8-sample frame, held stable.
- Samples are written in bit-reversed slot order, so downstream butterflies see natural-order outputs.

Parameters:
N, 3, log2 of sample width; each real/imag component is 2**N bits, two's complement (same convention as the butterfly stages).
PTS, 8, frame length; fixed at 8, with 3-bit indices.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  sample present.
in_ready  output  1  block can accept a sample this cycle.
in_last  input  1  marks the final sample of a frame.
in_r  input  2**N  sample real part.
in_i  input  2**N  sample imaginary part.
out_valid  output  1  full frame presented.
out_ready  input  1  downstream consumes the frame.
out_r  output  8*2**N  frame real parts; slot s at bits [s*2**N +: 2**N].
out_i  output  8*2**N  frame imaginary parts, same packing as out_r.
frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Write counter cnt, 3 bits. The k-th accepted sample is stored in slot bitrev3(k): order 0,4,2,6,1,5,3,7.
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1; out_r/out_i stable and unchanged until the output transfer.
- Transitions:
  - FILL -> HOLD on the input transfer with cnt==7. out_valid rises on the next edge (1-cycle latency from the last sample).
  - HOLD -> FILL on the output transfer; cnt=0.
  - in_ready rises in the following cycle. There is no same-cycle refill in the base build.
- Framing:
  - in_last on an input transfer with cnt<7: partial frame discarded, cnt=0, stay in FILL, frame_err pulses the next cycle.
  - cnt==7 without in_last: frame still completes (HOLD), frame_err pulses the next cycle.
  - in_last with cnt==7: normal completion, no error.
- in_valid while in_ready=0: ignored; the upstream source must hold its data.
- out_ready while out_valid=0: ignored.
- Reset:
  - Evaluated every edge, overrides all other activity.
  - State=FILL, cnt=0, out_valid=0, frame_err=0, all storage slots and out_r/out_i = 0.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-frame or mid-HOLD drops the frame with no error pulse.
- Data is stored unmodified: no scaling and no sign change. Scaling belongs to the butterfly stages.

Optional Feature:
FFT_INPUT_PINGPONG_EN:
- Defined: two frame banks.
  - Filling bank F while bank H is held.
  - in_ready=0 only when both banks are full.
  - When the last sample of F and the output transfer of H occur in the same cycle:
    - out_valid stays 1.
    - Outputs switch to F on the next edge.
    - F and H swap roles.
  - Sustained throughput: one sample per cycle, no bubbles.
  - Frames leave in arrival order.
- Undefined: single bank as described above; one idle cycle at each HOLD->FILL turnaround.

Decomposition:
- Package fft_pkg:
  - Width constant W = 2**N.
  - PTS = 8.
  - State encoding FILL/HOLD.
  - Function bitrev3, shared later with the output reorder stage.
- Sub-module bitrev_3: combinational 3-bit reverse, instantiated for the write-slot address.

Test Plan:
- Feed samples r=k, i=-k for k=0..7, in_last on k=7, out_ready=1 -> out_r slots [0,4,2,6,1,5,3,7]; out_valid high exactly 1 cycle after k=7 is accepted; frame_err never pulses.
- Hold out_ready=0 for 10 cycles after a frame -> outputs constant; in_ready=0; 3 extra in_valid pulses ignored; after release, the next frame fills correctly.
- in_last on the 4th sample -> frame_err 1-cycle pulse; no out_valid; the following 8-sample frame is correct.
- 8 samples without in_last -> frame presented plus a frame_err pulse.
- rst asserted at cnt=5 -> out_valid=0, outputs 0, cnt restarts; a subsequent frame is correct.
- With FFT_INPUT_PINGPONG_EN: 4 back-to-back frames with out_ready=1 -> in_ready constant 1, 32 accepted in 32 cycles, frames in order.
